// File: rtl/nvio3_scratchmem.sv
// Scratch memory of 128-bit lines behind a Wishbone-style responder:
// classic cycles, incrementing/wrapping bursts, and errors for out-of-window addresses.
module nvio3_scratchmem #(
    parameter logic [31:0] BASE       = 32'hFFFC0000,
    parameter int          LINES_LOG2 = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cs_i,
    input  logic         cyc_i,
    input  logic         stb_i,
    input  logic         we_i,
    input  logic [2:0]   cti_i,
    input  logic [1:0]   bte_i,
    input  logic [15:0]  sel_i,
    input  logic [31:0]  adr_i,
    input  logic [127:0] dat_i,
    output logic [127:0] dat_o,
    output logic         ack_o,
    output logic         err_o
);
    localparam int LW    = LINES_LOG2;
    localparam int DEPTH = 1 << LINES_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIC,
        S_BURST,
        S_HOLD,
        S_ERR
    } state_t;

    state_t        r_state, w_state_next;
    logic [LW-1:0] r_cnt, w_cnt_next;
    logic [LW-1:0] w_line, w_addr, w_mask;
    logic          r_ack, w_ack_next;
    logic          r_err, w_err_next;
    logic [127:0]  r_dat, w_rd;
    logic          w_req, w_in_range, w_acc, w_we;
    logic          w_unused_adr;

    assign w_req        = cs_i & cyc_i & stb_i;
    assign w_in_range   = (adr_i[31:LW+4] == BASE[31:LW+4]);
    assign w_line       = adr_i[LW+3:4];
    assign w_we         = w_acc & we_i;
    assign w_unused_adr = ^adr_i[3:0];

    // Wrapping bursts only step the low index bits selected by the mask.
    function automatic logic [LW-1:0] f_adv(input logic [LW-1:0] c, input logic [LW-1:0] m);
        return (c & ~m) | ((c + LW'(1)) & m);
    endfunction

    always_comb begin
        w_mask = '1;
        case (bte_i)
            2'b01:   w_mask = LW'(3);
            2'b10:   w_mask = LW'(7);
            2'b11:   w_mask = LW'(15);
            default: w_mask = '1;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_acc        = 1'b0;
        w_addr       = r_cnt;
        w_ack_next   = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_in_range) begin
                        w_acc      = 1'b1;
                        w_addr     = w_line;
                        w_ack_next = 1'b1;
                        if (cti_i == 3'b010) begin
                            w_cnt_next   = f_adv(w_line, w_mask);
                            w_state_next = S_BURST;
                        end else begin
                            w_state_next = S_CLASSIC;
                        end
                    end else begin
                        w_err_next   = 1'b1;
                        w_state_next = S_ERR;
                    end
                end
            end
            S_CLASSIC: w_state_next = S_HOLD;
            S_BURST: begin
                if (!cyc_i) begin
                    w_state_next = stb_i ? S_HOLD : S_IDLE;
                end else if (stb_i) begin
                    w_acc      = 1'b1;
                    w_ack_next = 1'b1;
                    w_cnt_next = f_adv(r_cnt, w_mask);
                    if (cti_i == 3'b111) begin
                        w_state_next = S_HOLD;
                    end
                end
            end
            S_HOLD, S_ERR: begin
                if (!stb_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ack   <= w_ack_next;
            r_err   <= w_err_next;
            if (w_acc && !we_i) begin
                r_dat <= w_rd;
            end
        end
    end

    // One narrow array per byte lane so each lane write enable maps onto its own RAM.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];

            always_ff @(posedge clk_i) begin
                if (w_we && sel_i[gi]) begin
                    r_mem[w_addr] <= dat_i[8*gi +: 8];
                end
            end

            assign w_rd[8*gi +: 8] = r_mem[w_addr];
        end
    endgenerate

    assign dat_o = r_dat;
    assign ack_o = r_ack;
    assign err_o = r_err;

endmodule

// File: tb/tb_nvio3_scratchmem.sv
// Directed bench for nvio3_scratchmem: read data is checked through a scoreboard queue
// filled as requests are driven and drained as acks arrive.
module tb_nvio3_scratchmem;
    localparam logic [31:0] BASE_A = 32'hFFFC0000;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cs_i, cyc_i, stb_i, we_i;
    logic [2:0]   cti_i;
    logic [1:0]   bte_i;
    logic [15:0]  sel_i;
    logic [31:0]  adr_i;
    logic [127:0] dat_i;
    logic [127:0] dat_o;
    logic         ack_o, err_o;

    int           n_vec;
    int           n_err;
    logic [127:0] exp_q[$];
    logic [127:0] model [1024];

    nvio3_scratchmem dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .cs_i  (cs_i),
        .cyc_i (cyc_i),
        .stb_i (stb_i),
        .we_i  (we_i),
        .cti_i (cti_i),
        .bte_i (bte_i),
        .sel_i (sel_i),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .ack_o (ack_o),
        .err_o (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic obs_read(input string tag);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: read ack with empty scoreboard, observed=%h", tag, dat_o);
        end else begin
            chk(tag, dat_o, exp_q.pop_front());
        end
    endtask

    function automatic logic [127:0] pat(input int k);
        logic [31:0] v;
        v = 32'(k);
        return {v ^ 32'hDEAD0000, v + 32'h01234567, v * 32'h01010101, ~v};
    endfunction

    function automatic logic [31:0] la(input int k);
        return BASE_A + (32'(k) << 4);
    endfunction

    task automatic mwrite(input int ln, input logic [15:0] s, input logic [127:0] d);
        for (int b = 0; b < 16; b++) begin
            if (s[b]) model[ln][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic bus_idle();
        cs_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        cti_i = 3'b000; bte_i = 2'b00; sel_i = 16'h0000;
        adr_i = 32'h0; dat_i = '0;
    endtask

    // Classic cycle; for reads d is the expected line. Strobe is held 'hold' extra cycles.
    task automatic classic(input logic wr, input logic [31:0] a, input logic [15:0] s,
                           input logic [127:0] d, input int hold, input string tag);
        cs_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = wr;
        cti_i = 3'b000; bte_i = 2'b00; adr_i = a; sel_i = s;
        dat_i = wr ? d : 128'h0;
        if (wr) mwrite(int'(a[13:4]), s, d);
        else exp_q.push_back(d);
        step();
        chk1({tag, " ack"}, ack_o, 1'b1);
        chk1({tag, " err"}, err_o, 1'b0);
        if (!wr) obs_read({tag, " data"});
        for (int h = 0; h < hold; h++) begin
            step();
            chk1($sformatf("%s held%0d no_ack", tag, h), ack_o, 1'b0);
        end
        bus_idle();
        step();
        chk1({tag, " single_ack"}, ack_o, 1'b0);
        step();
    endtask

    task automatic burst(input logic wr, input logic [1:0] bt, input int ln[4],
                         input logic [127:0] wd[4], input int gap_after, input string tag);
        cs_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = wr;
        cti_i = 3'b010; bte_i = bt; adr_i = la(ln[0]); sel_i = 16'hFFFF;
        dat_i = wr ? wd[0] : 128'h0;
        if (wr) mwrite(ln[0], 16'hFFFF, wd[0]);
        else exp_q.push_back(model[ln[0]]);
        for (int k = 0; k < 4; k++) begin
            step();
            chk1($sformatf("%s beat%0d ack", tag, k), ack_o, 1'b1);
            chk1($sformatf("%s beat%0d err", tag, k), err_o, 1'b0);
            if (!wr) obs_read($sformatf("%s beat%0d line%0d", tag, k, ln[k]));
            if (k < 3) begin
                if (gap_after == k) begin
                    stb_i = 1'b0;
                    for (int g = 0; g < 2; g++) begin
                        step();
                        chk1($sformatf("%s gap%0d no_ack", tag, g), ack_o, 1'b0);
                        if (!wr) chk($sformatf("%s gap%0d dat_hold", tag, g), dat_o, model[ln[k]]);
                    end
                    stb_i = 1'b1;
                end
                cti_i = (k == 2) ? 3'b111 : 3'b010;
                if (wr) begin
                    dat_i = wd[k+1];
                    mwrite(ln[k+1], 16'hFFFF, wd[k+1]);
                end else begin
                    exp_q.push_back(model[ln[k+1]]);
                end
            end
        end
        bus_idle();
        step();
        chk1({tag, " end no_ack"}, ack_o, 1'b0);
        step();
    endtask

    task automatic err_access(input logic wr, input logic [2:0] ct, input logic [31:0] a,
                              input string tag);
        cs_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = wr;
        cti_i = ct; bte_i = 2'b00; adr_i = a; sel_i = 16'hFFFF;
        dat_i = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
        step();
        chk1({tag, " err"}, err_o, 1'b1);
        chk1({tag, " ack"}, ack_o, 1'b0);
        for (int h = 0; h < 2; h++) begin
            step();
            chk1($sformatf("%s err_once%0d", tag, h), err_o, 1'b0);
            chk1($sformatf("%s no_ack%0d", tag, h), ack_o, 1'b0);
        end
        bus_idle();
        step();
        chk1({tag, " end err"}, err_o, 1'b0);
        step();
    endtask

    initial begin
        int           ln[4];
        logic [127:0] wd[4];

        n_vec = 0;
        n_err = 0;
        rst_i = 1'b1;
        bus_idle();
        repeat (3) step();
        chk1("reset ack", ack_o, 1'b0);
        chk1("reset err", err_o, 1'b0);
        chk("reset dat", dat_o, 128'h0);

        // Request on the very first edge after release.
        rst_i = 1'b0;
        classic(1'b1, la(1), 16'hFFFF, 128'h0123456789ABCDEF0123456789ABCDEF, 0, "wr_line1");
        classic(1'b0, la(1), 16'hFFFF, 128'h0123456789ABCDEF0123456789ABCDEF, 3, "rd_line1_held");

        classic(1'b1, la(5), 16'hFFFF, {128{1'b1}}, 0, "wr_line5_ff");
        classic(1'b1, la(5), 16'h000F, {96'h555555555555555555555555, 32'hAAAAAAAA}, 0, "wr_line5_sel");
        classic(1'b0, la(5), 16'hFFFF, {96'hFFFFFFFFFFFFFFFFFFFFFFFF, 32'hAAAAAAAA}, 0, "rd_line5_sel");
        classic(1'b1, la(5), 16'h0000, 128'h0, 0, "wr_line5_sel0");
        classic(1'b0, la(5), 16'hFFFF, {96'hFFFFFFFFFFFFFFFFFFFFFFFF, 32'hAAAAAAAA}, 0, "rd_line5_sel0");

        for (int k = 0; k < 5; k++) begin
            if (k != 1) classic(1'b1, la(k), 16'hFFFF, pat(k), 0, $sformatf("wr_line%0d", k));
        end

        for (int i = 0; i < 4; i++) wd[i] = '0;
        ln = '{2, 3, 0, 1};
        burst(1'b0, 2'b01, ln, wd, 4, "wrap4_rd");
        classic(1'b0, la(5), 16'hFFFF, {96'hFFFFFFFFFFFFFFFFFFFFFFFF, 32'hAAAAAAAA}, 0, "idle_after_burst");

        ln = '{1, 2, 3, 4};
        burst(1'b0, 2'b00, ln, wd, 1, "lin_gap_rd");

        ln = '{14, 15, 8, 9};
        for (int i = 0; i < 4; i++) wd[i] = pat(100 + i);
        burst(1'b1, 2'b10, ln, wd, 4, "wrap8_wr");
        for (int i = 0; i < 4; i++) begin
            classic(1'b0, la(ln[i]), 16'hFFFF, wd[i], 0, $sformatf("rd_wrap8_line%0d", ln[i]));
        end

        ln = '{1022, 1023, 0, 1};
        for (int i = 0; i < 4; i++) wd[i] = pat(200 + i);
        burst(1'b1, 2'b00, ln, wd, 4, "top_wr");
        burst(1'b0, 2'b00, ln, wd, 4, "top_rd");

        err_access(1'b1, 3'b010, BASE_A + 32'h00004000, "oor_burst");
        err_access(1'b0, 3'b000, BASE_A - 32'h00000010, "below_base");
        classic(1'b0, la(0), 16'hFFFF, pat(202), 0, "line0_after_err");

        cs_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1;
        adr_i = la(0); sel_i = 16'hFFFF; dat_i = 128'h0;
        for (int h = 0; h < 2; h++) begin
            step();
            chk1($sformatf("cs_low ack%0d", h), ack_o, 1'b0);
            chk1($sformatf("cs_low err%0d", h), err_o, 1'b0);
        end
        bus_idle();
        step();
        classic(1'b0, la(0), 16'hFFFF, pat(202), 0, "line0_after_cs_low");

        // Asynchronous reset while the third burst beat is being acked.
        cs_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
        cti_i = 3'b010; bte_i = 2'b00; adr_i = la(0); sel_i = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(model[k]);
            step();
            chk1($sformatf("rst_burst beat%0d ack", k), ack_o, 1'b1);
            obs_read($sformatf("rst_burst beat%0d line%0d", k, k));
        end
        #2;
        rst_i = 1'b1;
        #1;
        chk1("async_rst ack", ack_o, 1'b0);
        chk1("async_rst err", err_o, 1'b0);
        chk("async_rst dat", dat_o, 128'h0);
        bus_idle();
        step();
        chk1("in_rst ack", ack_o, 1'b0);
        rst_i = 1'b0;
        classic(1'b0, la(1), 16'hFFFF, pat(203), 0, "rd_after_rst");

        chk1("scoreboard drained", exp_q.size() == 0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nvio3_scratchmem.md
NVIO3_SCRATCHMEM -- requirements
Module: nvio3_scratchmem

Interface
REQ-001 The module SHALL have parameter BASE, default 32'hFFFC0000, giving the byte base address of the memory window.
REQ-002 The module SHALL have parameter LINES_LOG2, default 10, giving log2 of the number of 128-bit lines (16 KB by default).
REQ-003 The module SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port cs_i, input, 1 bit: the address decode selects this responder.
REQ-006 The module SHALL have ports cyc_i, stb_i and we_i, inputs, 1 bit each: bus cycle, strobe and write enable.
REQ-007 The module SHALL have port cti_i, input, 3 bits: cycle type (000 classic, 010 incrementing burst, 111 end of burst).
REQ-008 The module SHALL have port bte_i, input, 2 bits: burst wrap type (00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16).
REQ-009 The module SHALL have port sel_i, input, 16 bits: byte lane enables; bit n selects dat bits [8n+7:8n].
REQ-010 The module SHALL have port adr_i, input, 32 bits: byte address; bits [3:0] are ignored.
REQ-011 The module SHALL have port dat_i, input, 128 bits: write data.
REQ-012 The module SHALL have port dat_o, output, 128 bits: registered read data.
REQ-013 The module SHALL have ports ack_o and err_o, outputs, 1 bit each: registered acknowledge and registered error.

Function
REQ-014 Request = cs_i & cyc_i & stb_i; in-range = adr_i[31:LINES_LOG2+4] == BASE[31:LINES_LOG2+4]; line index = adr_i[LINES_LOG2+3:4].
REQ-015 The FSM SHALL have the states IDLE, CLASSIC, BURST, HOLD and ERR.
REQ-016 IDLE, request sampled at edge N, in-range, cti_i != 010: read or write the line at edge N, assert ack_o for cycle N+1, go to CLASSIC.
REQ-017 CLASSIC: deassert ack_o after exactly one cycle, go to HOLD; HOLD returns to IDLE when stb_i is sampled low. A held strobe SHALL never cause a second access.
REQ-018 IDLE, request, in-range, cti_i == 010: load the internal line counter from adr_i, perform the first access, go to BURST.
REQ-019 BURST: while stb_i is high, assert ack_o every cycle (one beat per cycle, zero wait states after the first) and advance the counter after each beat.
REQ-020 BURST with stb_i low: hold the counter and keep ack_o low (wait state). A beat acked with cti_i == 111, or cyc_i sampled low, SHALL end the burst: go to HOLD, or to IDLE if stb_i is already low.
REQ-021 Counter advance for bte 00: +1 modulo 2^LINES_LOG2.
REQ-022 Counter advance for bte 01, 10 and 11: only the low 2, 3 or 4 index bits increment and wrap; the upper bits are held.
REQ-023 Writes SHALL update only the byte lanes with sel_i set. sel_i == 0 SHALL be acked with memory unchanged.
REQ-024 Reads SHALL present the full line on dat_o in the same cycle as ack_o. dat_o SHALL hold its last value while ack_o is low.
REQ-025 A read beat to the line written by the previous beat SHALL return the new data (write-first).
REQ-026 IDLE with an out-of-range request: assert err_o for one cycle (never ack_o), perform no access, go to ERR; ERR returns to IDLE when stb_i is low. A burst to an out-of-range address SHALL be errored on its first beat only.
REQ-027 ack_o and err_o SHALL never be high in the same cycle.
REQ-028 A request with cs_i low SHALL be ignored entirely.

Reset
REQ-029 rst_i high SHALL immediately force state IDLE, ack_o=0, err_o=0, dat_o=0 and counter=0, independent of clk_i.
REQ-030 Reset mid-burst SHALL abort the cycle without further acks. Memory contents are undefined at power-up and SHALL NOT be cleared by reset.
REQ-031 After rst_i is released, the first request SHALL be accepted on the first rising edge of clk_i.

Verification
REQ-032 The bench SHALL cover: classic write 0x0123..CDEF to BASE+0x10 with sel=FFFF, then classic read -> ack_o one cycle after the strobe, dat_o=written value, exactly one ack per strobe.
REQ-033 The bench SHALL cover: write sel=000F of 0xAAAAAAAA to a line holding all-FF -> read returns FF..FF_AAAAAAAA.
REQ-034 The bench SHALL cover: 4-beat read burst, bte=01, start line 2 -> lines 2,3,0,1 returned on 4 consecutive acks; cti=111 on beat 4 -> FSM back in IDLE.
REQ-035 The bench SHALL cover: linear burst with stb_i dropped for 2 cycles mid-burst -> no ack during the gap, counter holds, sequence resumes without a skipped line.
REQ-036 The bench SHALL cover: access at BASE+(16<<LINES_LOG2) -> err_o one cycle, ack_o stays 0, memory unchanged.
REQ-037 The bench SHALL cover: rst_i asserted asynchronously during beat 3 of a burst -> ack_o, err_o and dat_o drop to 0 before the next clock edge, and a classic read after release is acked normally.
